// File: rtl/cacheline_mem_adapter.sv
// Memory-side responder for the data cache's line interface.
// Each fill or writeback request is serialised into WORDS word beats on a
// narrow req/ack memory port. Fill words are assembled into line_rdata and
// the evicted line is replayed word by word from a write buffer.
module cacheline_mem_adapter #(
  parameter int LINE_WIDTH = 256,
  parameter int WORD_WIDTH = 32,
  parameter int WORDS      = LINE_WIDTH / WORD_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           line_addr,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  line_done,
  output logic                  busy,
  output logic [31:0]           mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  // Beat counter width, line byte-offset width, word byte-offset width and
  // the width needed to address a bit inside the line.
  localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam int WB_W   = $clog2(WORD_WIDTH / 8);
  localparam int LB_W   = $clog2(LINE_WIDTH);
  localparam int WSH    = $clog2(WORD_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [BEAT_W-1:0]     beat;
  logic [31:0]           base;
  logic [LINE_WIDTH-1:0] wbuf;
  logic                  last_beat;
  logic [LB_W-1:0]       bit_off;
  logic [31:0]           beat_addr;
  logic                  take_req;

  assign last_beat = (beat == BEAT_W'(WORDS - 1));
  assign bit_off   = LB_W'(beat) << WSH;
  // Offset never carries out of the line offset bits: base is line aligned
  // and the last word sits at base + LINE_WIDTH/8 - WORD_WIDTH/8.
  assign beat_addr = base + (32'(beat) << WB_W);
  assign take_req  = (state == IDLE) && (line_read || line_write);

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and memory-port / handshake outputs.
  always_comb begin
    state_next = state;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    line_done  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        // Writeback wins over a simultaneous fill; the fill is not queued.
        if (line_write) begin
          state_next = WRITE;
        end else if (line_read) begin
          state_next = READ;
        end
      end
      READ: begin
        mem_re   = 1'b1;
        mem_addr = beat_addr;
        if (mem_ack && last_beat) begin
          state_next = DONE;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = beat_addr;
        mem_wdata = wbuf[bit_off +: WORD_WIDTH];
        if (mem_ack && last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        line_done  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Beat counter: cleared on request acceptance, advances on each acked beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      beat <= '0;
    end else begin
      case (state)
        IDLE: beat <= '0;
        READ, WRITE: begin
          if (mem_ack && !last_beat) begin
            beat <= beat + BEAT_W'(1);
          end
        end
        default: beat <= '0;
      endcase
    end
  end

  // Request capture: line-aligned base and writeback data, sampled only in IDLE
  // so requester inputs may change freely while busy.
  always_ff @(posedge CLK) begin
    if (take_req) begin
      base <= line_addr & ~((32'd1 << OFF_W) - 32'd1);
    end
    if ((state == IDLE) && line_write) begin
      wbuf <= line_wdata;
    end
  end

  // Fill line assembly; only a READ beat with ack touches line_rdata.
  always_ff @(posedge CLK) begin
    if (RST) begin
      line_rdata <= '0;
    end else if ((state == READ) && mem_ack) begin
      line_rdata[bit_off +: WORD_WIDTH] <= mem_rdata;
    end
  end

endmodule
